// File: rtl/math_io_ctrl.sv
// Operand-FIFO driver and result collector for the partially reconfigurable math module.
// Define MATH_IO_STAT_EN to capture statistic[15:0] alongside each result on res_stat.
module math_io_ctrl #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned RM_LATENCY = 1,
  parameter logic [15:0] SIG        = 16'hC001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] ain,
  output logic [31:0] bin,
  input  logic [31:0] result,
  input  logic [31:0] statistic,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [15:0] res_stat,
  output logic        rm_present,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(RM_LATENCY + 1);
  localparam logic [CW-1:0] CntLoad = CW'(RM_LATENCY);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StStall,
    StHold
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   ain_q, bin_q;
  logic [31:0]   res_data_q;
  logic          res_valid_q;
  logic          rm_present_q;

  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [31:0]   mem_a [DEPTH];
  logic [31:0]   mem_b [DEPTH];

  logic          empty, full, push, pop, capture;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign push    = op_valid && !full;
  assign pop     = (state_q == StIdle) && !empty && rm_present_q;
  assign capture = (state_q == StWait) && rm_present_q && (cnt_q == '0);

  assign op_ready   = !full;
  assign ain        = ain_q;
  assign bin        = bin_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign rm_present = rm_present_q;
  assign busy       = (state_q != StIdle) || !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rm_present_q <= 1'b0;
    end else begin
      rm_present_q <= (statistic[31:16] == SIG);
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr_q[AW-1:0]] <= op_a;
      mem_b[wr_ptr_q[AW-1:0]] <= op_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ain_q       <= '0;
      bin_q       <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            ain_q   <= mem_a[rd_ptr_q[AW-1:0]];
            bin_q   <= mem_b[rd_ptr_q[AW-1:0]];
            cnt_q   <= CntLoad;
            state_q <= StWait;
          end
        end
        StWait: begin
          // Losing the signature keeps ain/bin so the new module recomputes the same pair.
          if (!rm_present_q) begin
            state_q <= StStall;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            res_data_q  <= result;
            res_valid_q <= 1'b1;
            state_q     <= StHold;
          end
        end
        StStall: begin
          if (rm_present_q) begin
            cnt_q   <= CntLoad;
            state_q <= StWait;
          end
        end
        StHold: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef MATH_IO_STAT_EN
  logic [15:0] res_stat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_stat_q <= '0;
    end else if (capture) begin
      res_stat_q <= statistic[15:0];
    end
  end

  assign res_stat = res_stat_q;
`else
  logic unused_stat;

  assign unused_stat = ^{statistic[15:0], capture};
  assign res_stat    = '0;
`endif

endmodule
